// File: rtl/conway_serial_host_sequencer.sv
// Host-side sequencer for the 8x8 serial game-of-life core: loads a parallel grid
// MSB first, runs N generations, then unloads exactly DATA_SIZE bits into a result register.
module conway_serial_host_sequencer #(
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned GEN_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START_VALID,
  output logic                 START_READY,
  input  logic [DATA_SIZE-1:0] GRID_IN,
  input  logic [GEN_WIDTH-1:0] GENERATIONS,
  output logic                 RESULT_VALID,
  input  logic                 RESULT_READY,
  output logic [DATA_SIZE-1:0] GRID_OUT,
  output logic                 BUSY,
  output logic                 SER_DATA_IN,
  output logic [1:0]           SER_MODE,
  input  logic                 SER_DATA_OUT
);

  localparam int unsigned CW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    UNLOAD,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_LOAD = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_OUT  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_t;

  state_t                 state_q;
  mode_t                  mode_q;
  logic [DATA_SIZE-1:0]   tx_q;
  logic [DATA_SIZE-1:0]   rx_q;
  logic [DATA_SIZE-1:0]   grid_out_q;
  logic [GEN_WIDTH-1:0]   gen_cnt_q;
  logic [CW-1:0]          bit_cnt_q;
  logic                   ser_data_in_q;
  logic                   result_valid_q;
  logic                   busy_q;

  assign START_READY  = (state_q == IDLE);
  assign RESULT_VALID = result_valid_q;
  assign GRID_OUT     = grid_out_q;
  assign BUSY         = busy_q;
  assign SER_DATA_IN  = ser_data_in_q;
  assign SER_MODE     = mode_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= IDLE;
      mode_q         <= MODE_HOLD;
      tx_q           <= '0;
      rx_q           <= '0;
      grid_out_q     <= '0;
      gen_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      ser_data_in_q  <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START_VALID) begin
            state_q       <= LOAD;
            mode_q        <= MODE_LOAD;
            // tx_q holds the bits still to present; the MSB goes out directly
            tx_q          <= GRID_IN << 1;
            ser_data_in_q <= GRID_IN[DATA_SIZE-1];
            gen_cnt_q     <= GENERATIONS;
            bit_cnt_q     <= '0;
            busy_q        <= 1'b1;
          end
        end

        LOAD: begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_q     <= '0;
            tx_q          <= '0;
            ser_data_in_q <= 1'b0;
            if (gen_cnt_q != '0) begin
              state_q <= RUN;
              mode_q  <= MODE_RUN;
            end else begin
              state_q <= UNLOAD;
              mode_q  <= MODE_OUT;
            end
          end else begin
            bit_cnt_q     <= bit_cnt_q + CW'(1);
            ser_data_in_q <= tx_q[DATA_SIZE-1];
            tx_q          <= tx_q << 1;
          end
        end

        RUN: begin
          gen_cnt_q <= gen_cnt_q - GEN_WIDTH'(1);
          if (gen_cnt_q == GEN_WIDTH'(1)) begin
            state_q <= UNLOAD;
            mode_q  <= MODE_OUT;
          end
        end

        UNLOAD: begin
          rx_q <= {rx_q[DATA_SIZE-2:0], SER_DATA_OUT};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_q      <= '0;
            grid_out_q     <= {rx_q[DATA_SIZE-2:0], SER_DATA_OUT};
            result_valid_q <= 1'b1;
            mode_q         <= MODE_HOLD;
            busy_q         <= 1'b0;
            state_q        <= DONE;
          end else begin
            bit_cnt_q <= bit_cnt_q + CW'(1);
          end
        end

        DONE: begin
          if (RESULT_READY) begin
            result_valid_q <= 1'b0;
            state_q        <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          mode_q  <= MODE_HOLD;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/conway_serial_host_sequencer.md
Name: conway_serial_host_sequencer

Overview:
Host-side sequencer that sits directly upstream of the 8x8 serial game-of-life top and drives its DATA_IN and MODE pins. It accepts a parallel 64-bit grid and a generation count on a valid/ready handshake. It then serialises the grid in, steps the requested number of generations, and reads back exactly 64 bits. The final grid is presented on a valid/ready result port, so parallel-bus logic can use the serial core without managing mode timing.

Parameters:
DATA_SIZE, 64, grid bits per transfer; every unload reads exactly DATA_SIZE bits.
GEN_WIDTH, 16, width of the generation-count input and the run counter.

Ports:
CLK  input  1  system clock; also the clock of the serial core.
RESET  input  1  asynchronous, active-high reset.
START_VALID  input  1  request valid.
START_READY  output  1  high only in IDLE.
GRID_IN  input  DATA_SIZE  initial grid, captured on handshake.
GENERATIONS  input  GEN_WIDTH  generation count N, captured on handshake.
RESULT_VALID  output  1  GRID_OUT holds the final grid.
RESULT_READY  input  1  consumer accepts the result.
GRID_OUT  output  DATA_SIZE  final grid.
BUSY  output  1  high in LOAD, RUN or UNLOAD.
SER_DATA_IN  output  1  connects to the core's DATA_IN.
SER_MODE  output  2  connects to the core's MODE: 00 load, 01 run, 10 output, 11 hold.
SER_DATA_OUT  input  1  connects to the core's DATA_OUT.

Behaviour:
- Reset (async, active-high):
  - state = IDLE; SER_MODE = 11; SER_DATA_IN = 0.
  - START_READY = 1; RESULT_VALID = 0; BUSY = 0; GRID_OUT = 0; all counters = 0.
  - Mid-operation reset aborts immediately; the core's memory contents are then don't-care.
- All outputs are registered. No combinational path from any input to any output, except START_READY, which decodes the state register.
- FSM states: IDLE, LOAD, RUN, UNLOAD, DONE.
- IDLE -> LOAD:
  - Occurs at the edge E0 where START_VALID && START_READY.
  - Captures GRID_IN into the tx shift register and GENERATIONS into gen_cnt.
  - Sets SER_MODE = 00 and SER_DATA_IN = GRID_IN[DATA_SIZE-1].
- LOAD:
  - Transmission is MSB first: bit DATA_SIZE-1 is presented first, bit 0 last.
  - One bit is presented per cycle and shifted left at each edge.
  - The core samples at edges E1..E64.
  - bit_cnt counts 0..DATA_SIZE-1.
  - Exit: after the last bit go to RUN if N != 0, otherwise straight to UNLOAD.
- RUN:
  - SER_MODE = 01 for exactly N cycles; the core advances one generation per edge.
  - gen_cnt decrements each edge; exit to UNLOAD when it reaches 1.
  - N = 0 skips RUN entirely. N = 2^GEN_WIDTH-1 must complete without counter wrap.
- UNLOAD:
  - SER_MODE = 10 for exactly DATA_SIZE cycles; never more, never fewer.
  - SER_DATA_OUT is sampled at each edge and shifted into rx_shift at the LSB (shift left).
  - The first sample ends up in bit DATA_SIZE-1.
  - The sample is taken at the same edge that advances the core's output pointer, so the first sample is the core's pre-shift output.
- UNLOAD -> DONE:
  - At the final sample edge, GRID_OUT is loaded with the completed rx value.
  - At the same edge, RESULT_VALID = 1 and SER_MODE = 11.
  - RESULT_VALID is first high 128+N edges after E0 (for DATA_SIZE = 64).
- DONE:
  - GRID_OUT and RESULT_VALID are held stable until RESULT_READY.
  - On an edge with RESULT_VALID && RESULT_READY: go to IDLE and clear RESULT_VALID. GRID_OUT retains its value.
  - A new START is accepted no earlier than the following edge.
- START_VALID outside IDLE is ignored; START_READY = 0 there. GRID_IN and GENERATIONS changes outside the handshake edge have no effect.
- BUSY = (state in {LOAD, RUN, UNLOAD}).
- SER_DATA_IN = 0 in every state except LOAD.

Test Plan:
Bench: sequencer connected to the 8x8 serial game-of-life top; cell index = row*8+col; patterns kept away from the grid border.
1. Blinker, GRID_IN bits {27,28,29}, N=1 -> RESULT_VALID at E0+129; GRID_OUT bits {20,28,36} only; SER_MODE trace: 00 x64, 01 x1, 10 x64, then 11.
2. Same blinker, N=2 -> GRID_OUT bits {27,28,29}. Block {27,28,35,36}, N=5 -> GRID_OUT unchanged.
3. N=0, GRID_IN=64'hA5C3_0000_0000_3CF0 -> no 01 cycles; GRID_OUT = GRID_IN; RESULT_VALID at E0+128.
4. Backpressure: RESULT_READY held low for 20 cycles -> RESULT_VALID and GRID_OUT stable throughout, START_READY=0. Raise RESULT_READY -> IDLE next edge; a back-to-back START then completes correctly.
5. START_VALID held high during LOAD/RUN/UNLOAD with different GRID_IN -> no effect on SER_DATA_IN stream or result.
6. Assert RESET during RUN (N=100, cycle 30) -> SER_MODE=11, BUSY=0, RESULT_VALID=0 immediately. A subsequent blinker job with N=1 passes.
